// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: two clients share one unsigned 32x32->64 multiplier.
// Each client has a valid/ready request channel and a valid/ready response channel.
// The pipeline has two stages: S1 registers the operands and S2 holds each port's result.
// Optional macro MUL_ARB_STATS_EN builds saturating per-port grant counters.
// When the macro is not defined, both counters read 0.
module mul_share_arbiter #(
    parameter int unsigned STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [31:0]           req0_a,
    input  logic [31:0]           req0_b,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [31:0]           req1_a,
    input  logic [31:0]           req1_b,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic [63:0]           rsp0_r,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [63:0]           rsp1_r,
    output logic [STAT_WIDTH-1:0] grant_count0,
    output logic [STAT_WIDTH-1:0] grant_count1
);

    logic        op_valid_q, op_id_q, last_grant_q;
    logic [31:0] op_a_q, op_b_q;
    logic        rsp0_valid_q, rsp1_valid_q;
    logic [63:0] rsp0_r_q, rsp1_r_q;

    logic        elig0, elig1, grant0, grant1;
    logic        land0, land1;
    logic        rsp0_valid_d, rsp1_valid_d;
    logic [63:0] rsp0_r_d, rsp1_r_d;
    logic [31:0] pp_ll, pp_lh, pp_hl, pp_hh;
    logic [63:0] product;

    // Eligibility and round-robin grant; a port is blocked while its previous op sits in S1
    // or while its result slot is full and not draining this cycle.
    always_comb begin
        elig0  = req0_valid & ~(op_valid_q & ~op_id_q) & (~rsp0_valid_q | rsp0_ready);
        elig1  = req1_valid & ~(op_valid_q & op_id_q) & (~rsp1_valid_q | rsp1_ready);
        grant0 = elig0 & (~elig1 | last_grant_q);
        grant1 = elig1 & (~elig0 | ~last_grant_q);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Shared multiplier formed from four 16x16 partial products.
    always_comb begin
        pp_ll   = {16'b0, op_a_q[15:0]}  * {16'b0, op_b_q[15:0]};
        pp_lh   = {16'b0, op_a_q[15:0]}  * {16'b0, op_b_q[31:16]};
        pp_hl   = {16'b0, op_a_q[31:16]} * {16'b0, op_b_q[15:0]};
        pp_hh   = {16'b0, op_a_q[31:16]} * {16'b0, op_b_q[31:16]};
        product = {32'b0, pp_ll} + {16'b0, pp_lh, 16'b0} + {16'b0, pp_hl, 16'b0}
                + {pp_hh, 32'b0};
    end

    // Result-slot next state; a landing product overrides a same-edge drain.
    always_comb begin
        land0        = op_valid_q & ~op_id_q;
        land1        = op_valid_q & op_id_q;
        rsp0_valid_d = land0 | (rsp0_valid_q & ~rsp0_ready);
        rsp1_valid_d = land1 | (rsp1_valid_q & ~rsp1_ready);
        rsp0_r_d     = land0 ? product : rsp0_r_q;
        rsp1_r_d     = land1 ? product : rsp1_r_q;
    end

    // S1 operand stage and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_valid_q   <= 1'b0;
            op_id_q      <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            last_grant_q <= 1'b1;
        end else begin
            op_valid_q <= grant0 | grant1;
            if (grant0 | grant1) begin
                op_id_q      <= grant1;
                op_a_q       <= grant1 ? req1_a : req0_a;
                op_b_q       <= grant1 ? req1_b : req0_b;
                last_grant_q <= grant1;
            end
        end
    end

    // S2 per-port result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_r_q     <= '0;
            rsp1_r_q     <= '0;
        end else begin
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_r_q     <= rsp0_r_d;
            rsp1_r_q     <= rsp1_r_d;
        end
    end

    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_r     = rsp0_r_q;
    assign rsp1_r     = rsp1_r_q;

`ifdef MUL_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] grant_count0_q, grant_count1_q;

    // Saturating grant counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_count0_q <= '0;
            grant_count1_q <= '0;
        end else begin
            if (grant0 && (grant_count0_q != '1)) grant_count0_q <= grant_count0_q + STAT_WIDTH'(1);
            if (grant1 && (grant_count1_q != '1)) grant_count1_q <= grant_count1_q + STAT_WIDTH'(1);
        end
    end

    assign grant_count0 = grant_count0_q;
    assign grant_count1 = grant_count1_q;
`else
    assign grant_count0 = '0;
    assign grant_count1 = '0;
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed self-checking bench for mul_share_arbiter (counters 4 bits wide).
module tb_mul_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [63:0] rsp0_r, rsp1_r;
    logic [3:0]  grant_count0, grant_count1;

    int n_cmp = 0;
    int n_err = 0;

    mul_share_arbiter #(.STAT_WIDTH(4)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_r(rsp0_r),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_r(rsp1_r),
        .grant_count0(grant_count0), .grant_count1(grant_count1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] exp0 [3];
    logic [63:0] exp1 [3];
    logic [3:0]  exp_cnt0;

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        exp0[0] = 64'd6;   exp0[1] = 64'd20;  exp0[2] = 64'd42;
        exp1[0] = 64'd110; exp1[1] = 64'd156; exp1[2] = 64'd210;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_rsp0_valid", 64'(rsp0_valid), 64'd0);
        chk("rst_rsp1_valid", 64'(rsp1_valid), 64'd0);
        chk("rst_rsp0_r", rsp0_r, 64'd0);
        chk("rst_cnt0", 64'(grant_count0), 64'd0);
        chk("rst_ready0", 64'(req0_ready), 64'd0);
        tick();

        // Single op on port 0: 3*5.
        req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd5;
        #1;
        chk("single_ready0", 64'(req0_ready), 64'd1);
        chk("single_ready1", 64'(req1_ready), 64'd0);
        tick();
        req0_valid = 1'b0;
        chk("single_lat1_valid", 64'(rsp0_valid), 64'd0);
        tick();
        chk("single_valid", 64'(rsp0_valid), 64'd1);
        chk("single_r", rsp0_r, 64'd15);
        chk("single_rsp1_quiet", 64'(rsp1_valid), 64'd0);
        tick();
        chk("single_drained", 64'(rsp0_valid), 64'd0);

        // Max operands on port 1.
        req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF; req1_b = 32'hFFFF_FFFF;
        #1;
        chk("max_ready1", 64'(req1_ready), 64'd1);
        tick();
        req1_valid = 1'b0;
        tick();
        chk("max_valid", 64'(rsp1_valid), 64'd1);
        chk("max_r", rsp1_r, 64'hFFFF_FFFE_0000_0001);
        tick();
        chk("max_drained", 64'(rsp1_valid), 64'd0);

        // Contention: both ports request continuously, grants alternate from port 0.
        req0_valid = 1'b1; req0_a = 32'd2;  req0_b = 32'd3;
        req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd11;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("cont_ready0_%0d", i), 64'(req0_ready), 64'((i % 2) == 0));
            chk($sformatf("cont_ready1_%0d", i), 64'(req1_ready), 64'((i % 2) == 1));
            if (i >= 2) begin
                if ((i % 2) == 0) begin
                    chk($sformatf("cont_rsp0_v_%0d", i), 64'(rsp0_valid), 64'd1);
                    chk($sformatf("cont_rsp0_r_%0d", i), rsp0_r, exp0[(i-2)/2]);
                end else begin
                    chk($sformatf("cont_rsp1_v_%0d", i), 64'(rsp1_valid), 64'd1);
                    chk($sformatf("cont_rsp1_r_%0d", i), rsp1_r, exp1[(i-2)/2]);
                end
            end
            tick();
            if ((i % 2) == 0) begin
                req0_a = req0_a + 32'd2; req0_b = req0_b + 32'd2;
            end else begin
                req1_a = req1_a + 32'd2; req1_b = req1_b + 32'd2;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk("cont_tail0_v", 64'(rsp0_valid), 64'd1);
        chk("cont_tail0_r", rsp0_r, exp0[2]);
        tick();
        chk("cont_tail1_v", 64'(rsp1_valid), 64'd1);
        chk("cont_tail1_r", rsp1_r, exp1[2]);
        tick();
        chk("cont_idle0", 64'(rsp0_valid), 64'd0);
        chk("cont_idle1", 64'(rsp1_valid), 64'd0);

        // Backpressure on port 0.
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd8;
        #1;
        chk("bp_first_ready", 64'(req0_ready), 64'd1);
        tick();
        req0_a = 32'd9; req0_b = 32'd10;
        #1;
        chk("bp_s1_block", 64'(req0_ready), 64'd0);
        tick();
        chk("bp_valid", 64'(rsp0_valid), 64'd1);
        chk("bp_r", rsp0_r, 64'd56);
        chk("bp_full_block", 64'(req0_ready), 64'd0);
        tick();
        chk("bp_hold_valid", 64'(rsp0_valid), 64'd1);
        chk("bp_hold_r", rsp0_r, 64'd56);
        chk("bp_still_block", 64'(req0_ready), 64'd0);
        rsp0_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(req0_ready), 64'd1);
        tick();
        req0_valid = 1'b0;
        chk("bp_drained", 64'(rsp0_valid), 64'd0);
        tick();
        chk("bp_second_valid", 64'(rsp0_valid), 64'd1);
        chk("bp_second_r", rsp0_r, 64'd90);
        tick();

        // Reset one cycle after a port 0 grant (round-robin pointer then points at port 0).
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd5;
        #1;
        chk("rm_grant", 64'(req0_ready), 64'd1);
        tick();
        req0_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rm_rsp0_v", 64'(rsp0_valid), 64'd0);
        chk("rm_rsp1_v", 64'(rsp1_valid), 64'd0);
        chk("rm_rsp0_r", rsp0_r, 64'd0);
        tick();
        chk("rm_no_late_rsp", 64'(rsp0_valid), 64'd0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 32'd1; req0_b = 32'd1; req1_a = 32'd1; req1_b = 32'd1;
        #1;
        chk("rm_cont_ready0", 64'(req0_ready), 64'd1);
        chk("rm_cont_ready1", 64'(req1_ready), 64'd0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick(); tick();

        // 20 more port 0 ops; counter saturates (one op already counted since reset).
        req0_valid = 1'b1; req0_a = 32'd4; req0_b = 32'd4;
        for (int k = 0; k < 40; k++) begin
            #1;
            chk($sformatf("stat_ready0_%0d", k), 64'(req0_ready), 64'((k % 2) == 0));
            tick();
        end
        req0_valid = 1'b0;
        tick(); tick();
`ifdef MUL_ARB_STATS_EN
        exp_cnt0 = 4'hF;
`else
        exp_cnt0 = 4'h0;
`endif
        chk("stat_cnt0", 64'(grant_count0), 64'(exp_cnt0));
        chk("stat_cnt1", 64'(grant_count1), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
